// File: rtl/wsum_operand_sequencer.sv
// -----------------------------------------------------------------------------
// wsum_operand_sequencer
//
// Front/back-end controller for a 4-lane, fixed-latency weighted-sum datapath.
// Serial (data, weight) pairs are packed into four lane registers. Each full
// vector is presented to the datapath for one issue cycle and tagged through a
// LATENCY-deep shift register. When the tag emerges, the datapath result is
// written into a DEPTH-entry FIFO. An occupancy counter tracks in-flight plus
// queued results, so a vector is only issued when a FIFO slot is guaranteed.
//
// Optional feature: define WSUM_FLUSH_EN to add s_last. A pair accepted with
// s_last=1 closes the vector early and zero-fills the remaining lanes.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   s_valid/s_ready           input pair handshake
//   s_data, s_weight          input pair
//   s_last                    (WSUM_FLUSH_EN only) close vector early
//   pipe_data, pipe_weights   lane operands driven into the datapath
//   pipe_result               datapath weighted-sum output
//   m_valid/m_ready           result handshake
//   m_result                  FIFO head result
// -----------------------------------------------------------------------------
module wsum_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [WIDTH-1:0] s_weight,
`ifdef WSUM_FLUSH_EN
    input  logic             s_last,
`endif
    output logic [WIDTH-1:0] pipe_data    [0:3],
    output logic [WIDTH-1:0] pipe_weights [0:3],
    input  logic [WIDTH-1:0] pipe_result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_result
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FILL, WAIT_CREDIT, ISSUE} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg;
    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  fifo_cnt_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0]  fifo_mem [0:DEPTH-1];
    logic [LATENCY-1:0] tag_reg;
    logic [LATENCY:0]  tag_ext;

    logic accept, flush_last, close_vec, credit_ok, issue, push, pop;

`ifdef WSUM_FLUSH_EN
    assign flush_last = s_last;
`else
    assign flush_last = 1'b0;
`endif

    assign accept    = s_valid && s_ready;
    // A vector closes on the 4th lane or on an early s_last.
    assign close_vec = (cnt_reg == 2'd3) || flush_last;
    // Credit is judged on the registered occupancy only (no pop bypass).
    assign credit_ok = (occ_reg < OCC_W'(DEPTH));
    assign issue     = (state_reg == ISSUE);
    assign push      = tag_reg[LATENCY-1];
    assign pop       = m_valid && m_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= FILL;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        case (state_reg)
            FILL: begin
                // Gated by rst_n so s_ready reads 0 while reset is held.
                s_ready = rst_n;
                if (accept && close_vec)
                    state_next = credit_ok ? ISSUE : WAIT_CREDIT;
            end
            WAIT_CREDIT: begin
                if (credit_ok) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // ---------------- lane counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_reg <= 2'd0;
        else if (issue)  cnt_reg <= 2'd0;
        else if (accept) cnt_reg <= cnt_reg + 2'd1;
    end

    // ---------------- lane registers ----------------
    // Each lane is written when selected; on an early close, lanes above the
    // written one are cleared at the same edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_data[gi]    <= '0;
                    pipe_weights[gi] <= '0;
                end else if (accept) begin
                    if (cnt_reg == 2'(gi)) begin
                        pipe_data[gi]    <= s_data;
                        pipe_weights[gi] <= s_weight;
                    end else if (flush_last && (cnt_reg < 2'(gi))) begin
                        pipe_data[gi]    <= '0;
                        pipe_weights[gi] <= '0;
                    end
                end
            end
        end
    endgenerate

    // ---------------- latency tags ----------------
    assign tag_ext = {tag_reg, issue};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_reg <= '0;
        else        tag_reg <= tag_ext[LATENCY-1:0];
    end

    // ---------------- occupancy (in flight + queued) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // ---------------- result FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= pipe_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    assign m_valid  = (fifo_cnt_reg != '0);
    // Masked so the unwritten RAM never shows on m_result.
    assign m_result = m_valid ? fifo_mem[rd_ptr_reg] : '0;

endmodule
